// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// controller states, operand width and a two's-complement magnitude helper.
`timescale 1ns/1ps
package mdu_pkg;
    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction
endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the pipeline controller (master) and the
// multiply/divide unit (slave).
`timescale 1ns/1ps
interface mdu_if import mdu_pkg::*; ();
    logic             start;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (output start, op, a, b, input busy, done, hi, lo, div_zero);
    modport slave  (input start, op, a, b, output busy, done, hi, lo, div_zero);
endinterface

// File: rtl/mdu_addsub_step.sv
// One 33-bit add/subtract step shared by the shift-add multiply and the
// restoring divide: {cout, sum} = x + (sub ? ~y : y) + sub.
`timescale 1ns/1ps
module mdu_addsub_step import mdu_pkg::*; (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] total;

    assign total       = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{WIDTH{1'b0}}, sub};
    assign {cout, sum} = total;
endmodule

// File: rtl/mdu_seq.sv
// Iterative 32-bit MULTU/MULT/DIVU/DIV unit: WIDTH step cycles on operand
// magnitudes, then one sign-fix cycle that writes HI/LO and pulses done.
`timescale 1ns/1ps
module mdu_seq import mdu_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    mdu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t              state;
    logic [CW-1:0]       count;
    logic                is_div;
    logic                sa;
    logic                sb;
    logic [WIDTH-1:0]    acc_hi;
    logic [WIDTH-1:0]    acc_lo;
    logic [WIDTH-1:0]    b_mag;
    logic [WIDTH-1:0]    a_orig;

    logic                a_neg;
    logic                b_neg;
    logic [WIDTH-1:0]    rem_sh;
    logic [WIDTH-1:0]    step_x;
    logic [WIDTH-1:0]    step_y;
    logic [WIDTH-1:0]    step_sum;
    logic                step_cout;
    logic [2*WIDTH-1:0]  prod_fix;
    logic [WIDTH-1:0]    q_fix;
    logic [WIDTH-1:0]    r_fix;

    assign a_neg = bus.op[0] & bus.a[WIDTH-1];
    assign b_neg = bus.op[0] & bus.b[WIDTH-1];

    // acc_hi doubles as the partial product high half and the divide remainder;
    // acc_lo as the multiplier shift register and the quotient shift register.
    assign rem_sh = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    assign step_x = is_div ? rem_sh : acc_hi;
    assign step_y = (is_div || acc_lo[0]) ? b_mag : '0;

    mdu_addsub_step u_step (
        .x    (step_x),
        .y    (step_y),
        .sub  (is_div),
        .sum  (step_sum),
        .cout (step_cout)
    );

    assign prod_fix = (sa ^ sb) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign q_fix    = (sa ^ sb) ? -acc_lo : acc_lo;
    assign r_fix    = sa ? -acc_hi : acc_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            is_div       <= 1'b0;
            sa           <= 1'b0;
            sb           <= 1'b0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            b_mag        <= '0;
            a_orig       <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.hi       <= '0;
            bus.lo       <= '0;
            bus.div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        is_div   <= bus.op[1];
                        sa       <= a_neg;
                        sb       <= b_neg;
                        acc_hi   <= '0;
                        acc_lo   <= magnitude(bus.a, a_neg);
                        b_mag    <= magnitude(bus.b, b_neg);
                        a_orig   <= bus.a;
                        count    <= '0;
                        bus.busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc_hi <= step_cout ? step_sum : rem_sh;
                        acc_lo <= {acc_lo[WIDTH-2:0], step_cout};
                    end else begin
                        acc_hi <= {step_cout, step_sum[WIDTH-1:1]};
                        acc_lo <= {step_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH-1))
                        state <= FIX;
                end
                FIX: begin
                    // A zero divisor is the only case with a zero magnitude.
                    if (is_div && b_mag == '0) begin
                        bus.lo       <= '1;
                        bus.hi       <= a_orig;
                        bus.div_zero <= 1'b1;
                    end else if (is_div) begin
                        bus.lo       <= q_fix;
                        bus.hi       <= r_fix;
                        bus.div_zero <= 1'b0;
                    end else begin
                        {bus.hi, bus.lo} <= prod_fix;
                        bus.div_zero     <= 1'b0;
                    end
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: table of hand-computed results plus held-start
// throughput and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_mdu_seq;
    import mdu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mdu_if bus();

    mdu_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        op_t         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request while idle and follow it until done, bounded.
    task automatic applyStimulus(input op_t op, input logic [31:0] a, input logic [31:0] b,
                                 output int busy_cycles, output bit got_done, output bit overlap);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        busy_cycles = 0;
        got_done    = 1'b0;
        overlap     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.busy && bus.done) overlap = 1'b1;
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            if (bus.busy) busy_cycles++;
        end
    endtask

    initial begin
        int  bc;
        bit  gd;
        bit  ov;
        int  last_done;
        int  n_done;
        int  k;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{OP_MULTU, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0};
        vecs[7]  = '{OP_DIV,   32'h80000005, 32'h00000000, 32'h80000005, 32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[9]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

        bus.start = 1'b0;
        bus.op    = OP_MULTU;
        bus.a     = '0;
        bus.b     = '0;

        #12;
        checkOutput("reset busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("reset done", {31'b0, bus.done}, 32'd0);
        checkOutput("reset hi", bus.hi, 32'd0);
        checkOutput("reset lo", bus.lo, 32'd0);
        checkOutput("reset div_zero", {31'b0, bus.div_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, bc, gd, ov);
            checkOutput($sformatf("v%0d done seen", i), {31'b0, gd}, 32'd1);
            checkOutput($sformatf("v%0d busy cycles", i), bc, 32'd33);
            checkOutput($sformatf("v%0d busy&done", i), {31'b0, ov}, 32'd0);
            checkOutput($sformatf("v%0d hi", i), bus.hi, vecs[i].hi);
            checkOutput($sformatf("v%0d lo", i), bus.lo, vecs[i].lo);
            checkOutput($sformatf("v%0d div_zero", i), {31'b0, bus.div_zero}, {31'b0, vecs[i].dz});
            @(negedge clk);
            checkOutput($sformatf("v%0d done width", i), {31'b0, bus.done}, 32'd0);
        end

        // start held high with operands changing every cycle
        last_done = 0;
        n_done    = 0;
        for (int c = 0; c <= 140; c++) begin
            @(negedge clk);
            if (bus.busy && bus.done)
                checkOutput("held busy&done", 32'd1, 32'd0);
            if (bus.done) begin
                n_done++;
                k = c - 34;
                checkOutput($sformatf("held c%0d gap", c), c - last_done, 32'd34);
                checkOutput($sformatf("held c%0d lo", c), bus.lo, (k + 2) * (k + 3));
                checkOutput($sformatf("held c%0d hi", c), bus.hi, 32'd0);
                last_done = c;
            end
            bus.start = (c <= 102);
            bus.op    = OP_MULTU;
            bus.a     = c + 2;
            bus.b     = c + 3;
        end
        checkOutput("held done count", n_done, 32'd4);

        // asynchronous reset in the middle of a divide
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("async done", {31'b0, bus.done}, 32'd0);
        checkOutput("async hi", bus.hi, 32'd0);
        checkOutput("async lo", bus.lo, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        checkOutput("aborted op no done", n_done, 32'd0);

        applyStimulus(OP_DIVU, 32'd1000, 32'd3, bc, gd, ov);
        checkOutput("post-reset done seen", {31'b0, gd}, 32'd1);
        checkOutput("post-reset busy cycles", bc, 32'd33);
        checkOutput("post-reset lo", bus.lo, 32'd333);
        checkOutput("post-reset hi", bus.hi, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative 32-bit multiply/divide unit in the execute stage, beside the single-cycle ALU.
- Implements MULTU, MULT, DIVU and DIV.
- Each iteration drives one 33-bit add/subtract step; the 64-bit result goes to HI/LO.
- The pipeline controller handshakes with start/busy/done; results are held until the next operation completes.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while idle
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  input  WIDTH  multiplicand or dividend, captured at accept
- b  input  WIDTH  multiplier or divisor, captured at accept
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when hi/lo/div_zero update
- hi  output  WIDTH  product[63:32], or remainder
- lo  output  WIDTH  product[31:0], or quotient
- div_zero  output  1  last completed op was a divide with b==0

Behaviour:
- Reset (async, rst_n low): state IDLE, busy=0, done=0, hi=0, lo=0, div_zero=0, all internal registers 0. Reset mid-operation aborts it; no done is produced.
- States:
  - IDLE: start=1 at edge E0 accepts the request and moves to CALC. Operands and op are latched, count=0.
  - CALC: one iteration per edge, 32 iterations at E1..E32. At E32 (count==WIDTH-1) moves to FIX.
  - FIX: applies sign correction. At E33 writes hi/lo/div_zero, pulses done, returns to IDLE.
- Timing: busy=1 in the cycles following E0 up to E33 (33 cycles). done=1 for exactly the cycle after E33. busy and done are never high together.
- start is ignored while busy. start in the done cycle is accepted, so back-to-back throughput is one operation per 34 cycles.
- Accept, signed ops: latch the magnitudes |a| and |b| and record sa=a[31], sb=b[31]. Unsigned ops: sa=sb=0.
- Multiply (shift-add):
  - acc_hi = 0, acc_lo = |a|.
  - Each iteration: s = acc_hi + (acc_lo[0] ? |b| : 0) as a 33-bit sum, then {acc_hi,acc_lo} = {s,acc_lo} >> 1.
  - FIX: if sa^sb, negate the 64-bit {acc_hi,acc_lo}.
- Divide (restoring):
  - rem = 0, q = |a|.
  - Each iteration: rem' = {rem[30:0], q[31]}; d = rem' + ~|b| + 1 as a 33-bit sum.
  - If d[32]=1 (no borrow): rem = d[31:0] and shift in quotient bit 1. Otherwise rem = rem' and shift in 0.
  - FIX: quotient negated if sa^sb; remainder negated if sa.
- Divide by zero: computation runs the same 33 cycles and div_zero=1.
  - Result forced to lo=0xFFFFFFFF, hi=a (original dividend), for both DIVU and DIV.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, div_zero=0, with no special handling.
- Multiply ops always clear div_zero at completion.
- All arithmetic is modulo 2^WIDTH except the 33-bit step sum. Negation is two's complement.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV;
  - state encoding IDLE/CALC/FIX;
  - constant WIDTH=32.
- One sub-module, mdu_addsub_step:
  - combinational 33-bit step producing {cout, sum} = x + (sub ? ~y : y) + sub;
  - used for the shift-add and for the restoring subtract.
- Sign conversion and the FIX stage stay in mdu_seq.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> at E33 done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7 -> lo=14, hi=2, div_zero=0. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_zero=1. A following MULTU 3x4 -> lo=12, hi=0, div_zero=0.
- start held high continuously with changing a/b -> only the operands captured in IDLE and in each done cycle are used; done pulses every 34 cycles.
- rst_n pulsed low at cycle 15 of a DIVU -> outputs 0 immediately (asynchronous), no done pulse; the next start completes normally.
